// File: rtl/mux_nw_pipe_pkg.sv
// ============================================================================
//  Module : mux_pkg
//  Shared types and helpers for the N-way registered selector.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } mux_state_t;

    localparam int C_DEF_WIDTH = 32;

    // Out-of-range selects collapse onto the highest-numbered input.
    function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned n);
        return (sel < n) ? sel : n - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_skid_stage.sv
// ============================================================================
//  Module : mux_skid_stage
//  Two-entry skid buffer (main + skid register) with a registered in_ready.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_skid_stage
    import mux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    mux_state_t    r_state;
    mux_state_t    w_state_nxt;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic          r_in_ready;
    logic          w_accept;
    logic          w_pop;
    logic          w_load_main;
    logic          w_load_skid;
    logic          w_move_skid;

    assign w_accept  = in_valid && r_in_ready;
    assign w_pop     = (r_state != EMPTY) && out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;

    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_move_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_pop) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = TWO;
                end else if (w_pop) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a pop can happen
                if (w_pop) begin
                    w_move_skid = 1'b1;
                    w_state_nxt = ONE;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != TWO);
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_move_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_nw_pipe.sv
// ============================================================================
//  Module : mux_nw_pipe
//  N-way W-bit registered selector with valid/ready and a two-entry skid.
//  Optional sticky out-of-range flag enabled by macro MUX_SEL_CHK_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_nw_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int N     = 3,
    parameter int SELW  = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]      sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err
);

    localparam int C_PW = WIDTH + SELW;

    logic [SELW-1:0]  w_eff;
    logic [WIDTH-1:0] w_sel_data;
    logic [C_PW-1:0]  w_payload;
    logic [C_PW-1:0]  w_out_payload;

    assign w_eff = SELW'(clamp_sel(32'(sel), unsigned'(N)));

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_eff == SELW'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // The clamped index travels with the data so out_sel always matches it.
    assign w_payload = {w_eff, w_sel_data};

    mux_skid_stage #(
        .DW (C_PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (w_payload),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (w_out_payload),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data = w_out_payload[WIDTH-1:0];
    assign out_sel  = w_out_payload[C_PW-1:WIDTH];

`ifdef MUX_SEL_CHK_EN
    logic r_sel_err;
    logic w_accept;

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && (32'(sel) >= unsigned'(N))) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`else
    assign sel_err = 1'b0;
`endif

endmodule

`default_nettype wire
